// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM states, pprot bit encodings and default bus widths.
// The UART APB completer imports the same width defaults.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [2:0] PROT_PRIV      = 3'b001;
    localparam logic [2:0] PROT_NONSECURE = 3'b010;
    localparam logic [2:0] PROT_INSTR     = 3'b100;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/apb_requester_if.sv
// Command, response and APB4 signal bundle for the APB requester.
// master is the requester's view; slave is the view of whoever drives commands and plays the completer.
interface apb_requester_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    // cmd and rsp channels: a beat transfers on a rising edge where valid && ready are both high.
    // Once valid is raised, the sender holds valid and every payload field stable until that edge.
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_write;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic [DATA_W/8-1:0] cmd_strb;
    logic [2:0]          cmd_prot;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;
    logic                rsp_timeout;

    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [ADDR_W-1:0]   paddr;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W/8-1:0] pstrb;
    logic [2:0]          pprot;
    logic [DATA_W-1:0]   prdata;
    logic                pready;
    logic                pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  rsp_ready, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output rsp_ready, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot
    );

endinterface

// File: rtl/apb_requester.sv
// APB4 requester: turns one cmd beat into a SETUP/ACCESS transfer and returns the result on rsp.
// One transfer in flight; an ACCESS-phase timeout aborts transfers to a completer that never answers.
module apb_requester
    import apb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic   clk,
    input  logic   reset,
    apb_requester_if.master bus,
    output state_t dbg_state
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT) : {CNT_W{1'b1}};

    state_t              state, state_next;
    logic [CNT_W-1:0]    wait_cnt;
    logic                accept, done, abort;

    logic                psel_q, penable_q, pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [STRB_W-1:0]   pstrb_q;
    logic [2:0]          pprot_q;
    logic                rsp_valid_q, rsp_err_q, rsp_timeout_q;
    logic [DATA_W-1:0]   rsp_rdata_q;

    assign bus.cmd_ready = (state == IDLE) && !rsp_valid_q && !reset;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid && bus.cmd_ready) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                if (bus.pready) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
                    // This edge would take the wait count to TIMEOUT: give up on the completer.
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !bus.pready && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                psel_q   <= 1'b1;
                pwrite_q <= bus.cmd_write;
                paddr_q  <= bus.cmd_addr;
                pwdata_q <= bus.cmd_wdata;
                pstrb_q  <= bus.cmd_write ? bus.cmd_strb : '0;
                pprot_q  <= bus.cmd_prot;
            end
            if (state == SETUP) penable_q <= 1'b1;
            if (done || abort) begin
                psel_q        <= 1'b0;
                penable_q     <= 1'b0;
                rsp_valid_q   <= 1'b1;
                rsp_rdata_q   <= (done && !pwrite_q) ? bus.prdata : '0;
                rsp_err_q     <= abort ? 1'b1 : bus.pslverr;
                rsp_timeout_q <= abort;
            end else if (rsp_valid_q && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.pstrb       = pstrb_q;
    assign bus.pprot       = pprot_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign dbg_state       = state;

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester with TIMEOUT=4; inputs change and outputs are checked 1 ns after each rising edge.
module tb_apb_requester;
    import apb_pkg::*;

    logic   clk;
    logic   reset;
    state_t dbg_state;
    int     errors = 0;
    int     checks = 0;

    apb_requester_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [2:0] prot);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_strb  = strb;
        bus.cmd_prot  = prot;
    endtask

    task automatic rsp_handshake();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("rsp_valid_cleared", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.cmd_prot  = '0;
        bus.rsp_ready = 1'b0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_psel",      32'(bus.psel), 32'd0);
        check("rst_penable",   32'(bus.penable), 32'd0);
        check("rst_paddr",     bus.paddr, 32'd0);
        check("rst_pstrb",     32'(bus.pstrb), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_state",     32'(dbg_state), 32'(IDLE));
        reset = 1'b0;
        tick();

        // 1: zero-wait write
        bus.pready = 1'b1;
        send_cmd(1'b1, 32'h0000_0004, 32'h0000_00A5, 4'hF, PROT_PRIV);
        check("t1_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        check("t1_setup_psel",    32'(bus.psel), 32'd1);
        check("t1_setup_penable", 32'(bus.penable), 32'd0);
        check("t1_pwrite",        32'(bus.pwrite), 32'd1);
        check("t1_paddr",         bus.paddr, 32'h0000_0004);
        check("t1_pwdata",        bus.pwdata, 32'h0000_00A5);
        check("t1_pstrb",         32'(bus.pstrb), 32'hF);
        check("t1_pprot",         32'(bus.pprot), 32'(PROT_PRIV));
        tick();
        check("t1_access_psel",    32'(bus.psel), 32'd1);
        check("t1_access_penable", 32'(bus.penable), 32'd1);
        tick();
        check("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t1_rsp_err",   32'(bus.rsp_err), 32'd0);
        check("t1_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("t1_psel_low",  32'(bus.psel), 32'd0);
        rsp_handshake();

        // 2: read with 3 wait states
        bus.pready = 1'b0;
        send_cmd(1'b0, 32'h0000_0008, 32'hFFFF_FFFF, 4'hF, PROT_NONSECURE);
        tick();
        bus.cmd_valid = 1'b0;
        check("t2_setup_psel",  32'(bus.psel), 32'd1);
        check("t2_setup_pstrb", 32'(bus.pstrb), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t2_wait_penable", 32'(bus.penable), 32'd1);
            check("t2_wait_paddr",   bus.paddr, 32'h0000_0008);
            check("t2_wait_pstrb",   32'(bus.pstrb), 32'd0);
            check("t2_wait_rsp",     32'(bus.rsp_valid), 32'd0);
            tick();
        end
        bus.pready = 1'b1;
        bus.prdata = 32'h1234_5678;
        check("t2_ready_penable", 32'(bus.penable), 32'd1);
        tick();
        bus.pready = 1'b0;
        bus.prdata = 32'h0;
        check("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t2_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
        check("t2_rsp_err",   32'(bus.rsp_err), 32'd0);
        rsp_handshake();

        // 3: write answered with pslverr
        send_cmd(1'b1, 32'h0000_000C, 32'h0000_005A, 4'h3, 3'b000);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        bus.pready  = 1'b1;
        bus.pslverr = 1'b1;
        tick();
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        check("t3_rsp_valid",   32'(bus.rsp_valid), 32'd1);
        check("t3_rsp_err",     32'(bus.rsp_err), 32'd1);
        check("t3_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        check("t3_psel",        32'(bus.psel), 32'd0);
        check("t3_penable",     32'(bus.penable), 32'd0);
        rsp_handshake();

        // 4: timeout after 4 ACCESS cycles
        bus.prdata = 32'hDEAD_BEEF;
        send_cmd(1'b0, 32'h0000_0010, 32'h0, 4'h0, PROT_INSTR);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t4_access_penable", 32'(bus.penable), 32'd1);
            check("t4_access_psel",    32'(bus.psel), 32'd1);
            tick();
        end
        check("t4_psel",        32'(bus.psel), 32'd0);
        check("t4_penable",     32'(bus.penable), 32'd0);
        check("t4_rsp_valid",   32'(bus.rsp_valid), 32'd1);
        check("t4_rsp_err",     32'(bus.rsp_err), 32'd1);
        check("t4_rsp_timeout", 32'(bus.rsp_timeout), 32'd1);
        check("t4_rsp_rdata",   bus.rsp_rdata, 32'd0);
        bus.prdata = 32'h0;

        // 5: response back-pressure blocks new commands
        send_cmd(1'b1, 32'h0000_0014, 32'h0000_0077, 4'hF, 3'b000);
        for (int i = 0; i < 5; i++) begin
            check("t5_cmd_ready",   32'(bus.cmd_ready), 32'd0);
            check("t5_psel",        32'(bus.psel), 32'd0);
            check("t5_rsp_valid",   32'(bus.rsp_valid), 32'd1);
            check("t5_rsp_timeout", 32'(bus.rsp_timeout), 32'd1);
            check("t5_rsp_rdata",   bus.rsp_rdata, 32'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        check("t5_no_same_cycle_accept", 32'(bus.cmd_ready), 32'd0);
        tick();
        bus.rsp_ready = 1'b0;
        check("t5_rsp_done",     32'(bus.rsp_valid), 32'd0);
        check("t5_cmd_ready_up", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        check("t5_new_psel",  32'(bus.psel), 32'd1);
        check("t5_new_paddr", bus.paddr, 32'h0000_0014);
        bus.pready = 1'b1;
        tick();
        tick();
        bus.pready = 1'b0;
        check("t5_new_rsp_valid",   32'(bus.rsp_valid), 32'd1);
        check("t5_new_rsp_err",     32'(bus.rsp_err), 32'd0);
        check("t5_new_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        rsp_handshake();

        // 6: reset asserted during ACCESS
        send_cmd(1'b0, 32'h0000_0018, 32'h0, 4'h0, 3'b000);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        check("t6_in_access", 32'(bus.penable), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_psel",      32'(bus.psel), 32'd0);
        check("t6_async_penable",   32'(bus.penable), 32'd0);
        check("t6_async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("t6_async_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("t6_async_state",     32'(dbg_state), 32'(IDLE));
        #2;
        reset = 1'b0;
        tick();
        bus.pready = 1'b1;
        bus.prdata = 32'hCAFE_F00D;
        send_cmd(1'b0, 32'h0000_001C, 32'h0, 4'hF, 3'b000);
        check("t6_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        check("t6_setup_paddr", bus.paddr, 32'h0000_001C);
        tick();
        tick();
        bus.pready = 1'b0;
        check("t6_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("t6_rsp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
        check("t6_rsp_err",   32'(bus.rsp_err), 32'd0);
        rsp_handshake();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- APB4 requester (initiator) that drives the register interface of the APB-attached UART peripheral, or any single APB4 completer.
- Converts a simple valid/ready command channel into APB SETUP/ACCESS transfers and returns the completer's result on a valid/ready response channel.
- One transfer outstanding at a time. An ACCESS-phase timeout guards against a stalled completer.

Parameters:
- ADDR_W, 32, width of cmd_addr/paddr.
- DATA_W, 32, width of data buses; must be 8, 16 or 32.
- TIMEOUT, 255, maximum ACCESS cycles with pready low before abort; 0 disables the timeout.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  write byte strobes.
- cmd_prot  in  3  protection attributes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes or aborted transfers.
- rsp_err  out  1  pslverr, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- psel, penable, pwrite  out  1  APB controls.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pstrb  out  DATA_W/8  APB strobes.
- pprot  out  3  APB protection.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.

Behaviour:
- Reset (asynchronous):
  - All registered outputs go to 0: psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid, rsp_rdata, rsp_err, rsp_timeout.
  - FSM goes to IDLE; timeout counter clears.
  - cmd_ready is forced 0 while reset is high.
- FSM states and transitions:
  - IDLE: cmd_ready = !rsp_valid && !reset. On cmd_valid && cmd_ready, latch the command into the APB output registers and go to SETUP.
  - SETUP: psel=1, penable=0. Unconditionally go to ACCESS next cycle.
  - ACCESS: psel=1, penable=1. Counter increments each cycle pready=0.
    - On pready=1: capture the response, deassert psel/penable, go to IDLE.
    - If the counter reaches TIMEOUT with pready=0 (TIMEOUT≠0): abort, same exit path.
- Response capture:
  - Normal completion: rsp_rdata = prdata for reads, 0 for writes; rsp_err = pslverr; rsp_timeout = 0.
  - Abort: rsp_rdata = 0, rsp_err = 1, rsp_timeout = 1.
- Response channel:
  - rsp_valid and all rsp_* fields are held stable until rsp_valid && rsp_ready.
  - A new command cannot be accepted while rsp_valid=1, even in the same cycle rsp_ready is high; acceptance is possible the following cycle.
- Stability and field rules:
  - paddr, pwrite, pwdata, pstrb, pprot are stable from SETUP through the end of ACCESS.
  - pstrb is forced to 0 for reads, per APB4.
  - pslverr and prdata are sampled only when pready=1 in ACCESS.
- Latency: command accepted at edge N gives psel=1 in cycle N+1 and penable=1 in N+2. With zero wait states, rsp_valid=1 in N+3.
- Timeout counter: width clog2(TIMEOUT+1). It saturates and never wraps, and clears on entry to SETUP.
- An abort is a deliberate APB protocol exception, accepted for recovery from a dead completer.
- Reset mid-transfer: the bus idles immediately (asynchronously); any pending response is discarded.

Decomposition:
- Shared package apb_pkg holds:
  - state enum {IDLE, SETUP, ACCESS};
  - pprot encoding constants (PRIV, NONSECURE, INSTR bits);
  - default ADDR_W/DATA_W localparams, shared with the UART APB completer.
- Single module; no sub-module is warranted.

Test Plan:
1. Write 0x0000_0004 ← 0x0000_00A5, strb 0xF, pready tied 1 -> psel rises cycle N+1, penable N+2, pwdata 0xA5, rsp_valid N+3 with rsp_err=0, rsp_rdata=0.
2. Read 0x0000_0008, completer inserts 3 wait states then prdata=0x1234_5678 -> pstrb=0 throughout, address stable, rsp_rdata=0x1234_5678 at N+6.
3. Write with pslverr=1 on the pready cycle -> rsp_err=1, rsp_timeout=0, psel/penable low next cycle.
4. TIMEOUT=4, pready held 0 -> psel/penable drop after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
5. rsp_ready held 0 for 5 cycles with cmd_valid=1 -> cmd_ready=0, psel stays 0, response fields unchanged. rsp_ready=1 -> handshake, next command accepted the following cycle.
6. Assert reset during ACCESS -> psel, penable, rsp_valid go 0 without waiting for a clock edge; after release, a fresh read completes normally.
